spi_cmd_regfile: RTL

//  Byte-level command decoder and register file downstream of spi_slave.

---
 rtl/spi_cmd_regfile.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_regfile.sv
// Command decoder and small register file behind an SPI byte interface.
// Executes register read/write commands and drives an 8-bit output port with optional blink/invert.
module spi_cmd_regfile #(
   parameter logic [7:0] ID      = 8'hA5,
   parameter int         DIV_PRE = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ss,
   input  logic [7:0] data_in,
   input  logic       data_rdy,
   output logic [7:0] data_out,
   output logic       data_latch,
   output logic [7:0] out
);

   localparam int CW = 8 + DIV_PRE;
   localparam logic [CW-1:0] LOW_MASK = CW'((64'd1 << DIV_PRE) - 64'd1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WDATA   = 2'd1,
      RDUMMY  = 2'd2,
      DISCARD = 2'd3
   } state_t;

   state_t        state;
   state_t        next_state;
   logic          ss_meta;
   logic          ss_sync;
   logic [7:0]    out_reg;
   logic [1:0]    mode;
   logic [7:0]    prescale;
   logic [7:0]    scratch;
   logic [3:0]    err_cnt;
   logic [2:0]    cmd_addr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_limit;
   logic          phase;

   logic          latch_en;
   logic [7:0]    latch_val;
   logic [7:0]    read_val;
   logic [7:0]    status;
   logic          write_en;
   logic          err_inc;
   logic          addr_load;
   logic          prescale_wr;

   assign status      = {state, 2'b00, err_cnt};
   assign prescale_wr = write_en && (cmd_addr == 3'd2);
   assign cnt_limit   = (CW'(prescale) << DIV_PRE) | LOW_MASK;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_meta <= 1'b0;
         ss_sync <= 1'b0;
      end else begin
         ss_meta <= ss;
         ss_sync <= ss_meta;
      end
   end

   always_comb begin
      read_val = 8'h00;
      case (data_in[2:0])
         3'd0:    read_val = out_reg;
         3'd1:    read_val = {6'b0, mode};
         3'd2:    read_val = prescale;
         3'd3:    read_val = scratch;
         3'd4:    read_val = status;
         3'd7:    read_val = ID;
         default: read_val = 8'h00;
      endcase
   end

   // Byte-driven command decode; a synced frame end overrides whatever the byte asked for.
   always_comb begin
      next_state = state;
      latch_en   = 1'b0;
      latch_val  = data_in[7] ? read_val : status;
      write_en   = 1'b0;
      err_inc    = 1'b0;
      addr_load  = 1'b0;
      if (data_rdy) begin
         case (state)
            IDLE: begin
               if (data_in[6:3] != 4'b0000) begin
                  next_state = DISCARD;
                  err_inc    = 1'b1;
               end else begin
                  addr_load  = 1'b1;
                  latch_en   = 1'b1;
                  next_state = data_in[7] ? RDUMMY : WDATA;
               end
            end
            WDATA: begin
               next_state = IDLE;
               if (cmd_addr[2]) err_inc = 1'b1;
               else             write_en = 1'b1;
            end
            RDUMMY:  next_state = IDLE;
            DISCARD: next_state = DISCARD;
            default: next_state = IDLE;
         endcase
      end
      if (ss_sync) next_state = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cmd_addr   <= 3'd0;
         data_out   <= 8'h00;
         data_latch <= 1'b0;
         err_cnt    <= 4'd0;
      end else begin
         state      <= next_state;
         data_latch <= latch_en;
         if (addr_load)                     cmd_addr <= data_in[2:0];
         if (latch_en)                      data_out <= latch_val;
         if (err_inc && err_cnt != 4'hF)    err_cnt  <= err_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_reg  <= 8'h00;
         mode     <= 2'b00;
         prescale <= 8'h00;
         scratch  <= 8'h00;
      end else if (write_en) begin
         case (cmd_addr)
            3'd0:    out_reg  <= data_in;
            3'd1:    mode     <= data_in[1:0];
            3'd2:    prescale <= data_in;
            3'd3:    scratch  <= data_in;
            default: ;
         endcase
      end
   end

   // Blink timebase; the phase survives a prescale rewrite, only the count restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!mode[0]) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (prescale_wr) begin
         cnt <= '0;
      end else if (cnt == cnt_limit) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) out <= 8'h00;
      else     out <= (mode[0] ? (phase ? out_reg : 8'h00) : out_reg) ^ {8{mode[1]}};
   end

endmodule
